// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Optional bus-lock grant extension is enabled by defining DM_ARB_LOCK_EN.
module dm_arbiter #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LOCK_MAX    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_wr,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic        rr_q, rr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        grant_sel;
    logic        bad;

`ifdef DM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_lock;
    logic             prev_req;

    assign prev_lock = sel_q ? lock1 : lock0;
    assign prev_req  = sel_q ? req1 : req0;
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    assign bad = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);

    // Winner when sampled in IDLE; a lone requester always wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1) begin
            grant_sel = rr_q;
        end else if (req1) begin
            grant_sel = 1'b1;
        end
`ifdef DM_ARB_LOCK_EN
        // cnt_q == 0 means nothing granted since reset, so no lock holder yet.
        if ((cnt_q != '0) && (cnt_q < CNT_MAX) && prev_lock && prev_req) begin
            grant_sel = sel_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DM_ARB_LOCK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = grant_sel;
                    we_d    = grant_sel ? we1 : we0;
                    addr_d  = grant_sel ? addr1 : addr0;
                    wdata_d = grant_sel ? wdata1 : wdata0;
                    rr_d    = ~grant_sel;
                    state_d = ISSUE;
`ifdef DM_ARB_LOCK_EN
                    if ((grant_sel == sel_q) && (cnt_q != '0) &&
                        (grant_sel ? lock1 : lock0)) begin
                        cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
`endif
                end
            end
            ISSUE: begin
                rdata_d = (bad || we_q) ? 32'h0 : mem_rd;
                err_d   = bad;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            rr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef DM_ARB_LOCK_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DM_ARB_LOCK_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Latched fields only change at grant, so the memory bus holds outside ISSUE.
    assign mem_addr = addr_q;
    assign mem_wd   = wdata_q;
    assign mem_wr   = (state_q == ISSUE) && we_q && !bad;
    assign ack0     = (state_q == RESP) && !sel_q;
    assign ack1     = (state_q == RESP) && sel_q;
    assign rdata    = rdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: memory model, ack scoreboard, scenario tasks.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, err, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[11:2]] <= mem_wd;
    end

    function automatic logic [31:0] init_val(input int idx);
        return 32'hA500_0000 + 32'(idx) * 32'h0001_0103;
    endfunction

    // Scoreboard: every ack pops the oldest expected completion.
    always @(negedge clk) begin
        if (ack0 && ack1) begin
            checks++;
            errors++;
            $display("FAIL both_acks: ack0=%b ack1=%b required one-hot", ack0, ack1);
        end else if (ack0 || ack1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack1=%b with empty scoreboard", ack1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ack1 !== e.id || rdata !== e.rdata || err !== e.err) begin
                    errors++;
                    $display("FAIL ack_data: got id=%0d rdata=%h err=%b required id=%0d rdata=%h err=%b",
                             ack1, rdata, err, e.id, e.rdata, e.err);
                end else begin
                    $display("ack id=%0d rdata=%h err=%b t=%0t", ack1, rdata, err, $time);
                end
            end
        end
    end

    task automatic set_req(input logic port, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        if (port) begin
            req1 = 1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    // Waits for the port's ack; reports cycles taken and write strobes seen (cyc=-1 on timeout).
    task automatic wait_ack(input logic port, output int cyc, output int wr,
                            output logic [31:0] wa);
        cyc = -1; wr = 0; wa = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_wr === 1'b1) begin
                wr++;
                wa = mem_addr;
            end
            if ((port ? ack1 : ack0) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack0, ack1, err, mem_wr} !== 4'b0 || rdata !== 0 || mem_addr !== 0 || mem_wd !== 0) begin
            errors++;
            $display("FAIL reset_state: ack0=%b ack1=%b err=%b mem_wr=%b rdata=%h mem_addr=%h mem_wd=%h required all 0",
                     ack0, ack1, err, mem_wr, rdata, mem_addr, mem_wd);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_store();
        int c, w;
        logic [31:0] a;
        sb.push_back('{1'b0, 32'h0, 1'b0});
        set_req(0, 1, 32'h10, 32'hDEADBEEF);
        wait_ack(0, c, w, a);
        req0 = 0;
        checks++;
        if (c !== 2 || w !== 1 || a !== 32'h10) begin
            errors++;
            $display("FAIL store_timing: ack_cycles=%0d wr_cycles=%0d wr_addr=%h required 2 1 00000010", c, w, a);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_mem: mem[4]=%h required deadbeef", mem[4]);
        end
        @(negedge clk);
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        set_req(0, 0, 32'h10, 32'h0);
        wait_ack(0, c, w, a);
        req0 = 0;
        checks++;
        if (c !== 2 || w !== 0) begin
            errors++;
            $display("FAIL load_timing: ack_cycles=%0d wr_cycles=%0d required 2 0", c, w);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        int c, w;
        logic [31:0] a;
        sb.push_back('{1'b0, 32'h0, 1'b1});
        set_req(0, 1, 32'h13, 32'h12345678);
        wait_ack(0, c, w, a);
        req0 = 0;
        checks++;
        if (c !== 2 || w !== 0) begin
            errors++;
            $display("FAIL misaligned_store: ack_cycles=%0d wr_cycles=%0d required 2 0", c, w);
        end
        @(negedge clk);
        sb.push_back('{1'b1, 32'h0, 1'b1});
        set_req(1, 0, 32'h1000, 32'h0);
        wait_ack(1, c, w, a);
        req1 = 0;
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL oob_load: ack_cycles=%0d required 2", c);
        end
        @(negedge clk);
        // Last legal word must not be flagged.
        sb.push_back('{1'b0, init_val(1023), 1'b0});
        set_req(0, 0, 32'hFFC, 32'h0);
        wait_ack(0, c, w, a);
        req0 = 0;
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL last_word_load: ack_cycles=%0d required 2", c);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int n0 = 0, n1 = 0;
        rst_n = 0;
        set_req(0, 0, 32'h40, 32'h0);
        set_req(1, 0, 32'h80, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b0, init_val(16), 1'b0});
            sb.push_back('{1'b1, init_val(32), 1'b0});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 60 && (n0 < 4 || n1 < 4); i++) begin
            @(negedge clk);
            if (ack0 === 1'b1) begin
                n0++;
                if (n0 == 4) req0 = 0;
            end
            if (ack1 === 1'b1) begin
                n1++;
                if (n1 == 4) req1 = 0;
            end
        end
        checks++;
        if (n0 !== 4 || n1 !== 4) begin
            errors++;
            $display("FAIL contention_count: acks0=%0d acks1=%0d required 4 4", n0, n1);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int nack = 0;
        set_req(0, 1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue: mem_wr=%b required 1", mem_wr);
        end
        #1;
        rst_n = 0;
        req0 = 0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midrst_drop: mem_wr=%b mem_addr=%h required 0 00000000", mem_wr, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem[8] !== init_val(8)) begin
            errors++;
            $display("FAIL midrst_mem: mem[8]=%h required %h", mem[8], init_val(8));
        end
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) nack++;
        end
        checks++;
        if (nack !== 0) begin
            errors++;
            $display("FAIL midrst_ack: stray_acks=%0d required 0", nack);
        end
    endtask

    task automatic test_back_to_back();
        int t [3];
        int n = 0, c, w;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) sb.push_back('{1'b1, 32'h0, 1'b0});
        set_req(1, 1, 32'h200, 32'h1111_0000);
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1) begin
                t[n] = i;
                n++;
                if (n == 3) req1 = 0;
                else set_req(1, 1, 32'h200 + 32'(4 * n), 32'h1111_0000 + 32'(n));
            end
        end
        checks++;
        if (n !== 3 || t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: acks=%0d gaps=%0d,%0d required 3 acks gaps 3,3",
                     n, t[1] - t[0], t[2] - t[1]);
        end
        @(negedge clk);
        sb.push_back('{1'b0, 32'h1111_0002, 1'b0});
        set_req(0, 0, 32'h208, 32'h0);
        wait_ack(0, c, w, a);
        req0 = 0;
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL b2b_readback: ack_cycles=%0d required 2", c);
        end
        @(negedge clk);
    endtask

`ifdef DM_ARB_LOCK_EN
    task automatic test_lock();
        int n = 0;
        rst_n = 0;
        lock0 = 1;
        set_req(0, 0, 32'h40, 32'h0);
        set_req(1, 0, 32'h80, 32'h0);
        for (int i = 0; i < 8; i++) sb.push_back('{1'b0, init_val(16), 1'b0});
        sb.push_back('{1'b1, init_val(32), 1'b0});
        sb.push_back('{1'b0, init_val(16), 1'b0});
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 60 && n < 10; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) n++;
            if (n == 10) begin
                req0 = 0; req1 = 0;
            end
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL lock_count: acks=%0d required 10", n);
        end
        lock0 = 0; req0 = 0; req1 = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        test_reset();
        test_single_store();
        test_errors();
        test_contention();
        test_reset_mid_op();
        test_back_to_back();
`ifdef DM_ARB_LOCK_EN
        test_lock();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
